// File: rtl/c2h_cmpt_packer.sv
// c2h_cmpt_packer: sits between the C2H traffic generator and the QDMA C2H
// stream/CMPT ports. Beats pass through a 1-deep skid stage tagged with
// ctrl_len, qid and mty; every packet pushes one completion entry into a
// small FIFO, and beat-count/length mismatches are counted.
// Optional feature macro: CMPT_TIMESTAMP_EN (free-running cycle timestamp
// in completion bits [95:64]; zero when undefined).
//
// state    | meaning
// ST_IDLE  | between packets; next accepted beat starts a packet
// ST_PKT   | packet open, CMPT slot reserved, waiting for s_last
module c2h_cmpt_packer #(
    parameter int DATA_W     = 512,
    parameter int CMPT_W     = 128,
    parameter int CMPT_DEPTH = 16,
    parameter int QID_W      = 11
) (
    input  logic              axi_aclk,
    input  logic              axi_areset,
    input  logic [15:0]       cfg_pkt_len,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic [QID_W-1:0]  s_qid,
    output logic              s_ready,
    output logic              m_c2h_tvalid,
    output logic [DATA_W-1:0] m_c2h_tdata,
    output logic              m_c2h_tlast,
    output logic [5:0]        m_c2h_mty,
    output logic [15:0]       m_c2h_ctrl_len,
    output logic [QID_W-1:0]  m_c2h_ctrl_qid,
    input  logic              m_c2h_tready,
    output logic              m_cmpt_tvalid,
    output logic [CMPT_W-1:0] m_cmpt_tdata,
    input  logic              m_cmpt_tready,
    output logic [31:0]       stat_pkt_cnt,
    output logic [15:0]       stat_len_err
);

    localparam int AW = $clog2(CMPT_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = 1 + 6 + 16 + QID_W + DATA_W;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PKT  = 1'b1;

    logic [0:0]        state;
    logic [15:0]       len_q;
    logic [QID_W-1:0]  qid_q;
    logic [15:0]       beat_cnt;
    logic [15:0]       seq;

    logic              s_first;
    logic              s_acc;
    logic [15:0]       cur_len;
    logic [QID_W-1:0]  cur_qid;
    logic [5:0]        cur_mty;
    logic [15:0]       beats_now;
    logic [15:0]       beats_exp;
    logic              len_err;
    logic [31:0]       cur_ts;

    logic [BW-1:0]     in_beat;
    logic [BW-1:0]     out_beat;
    logic [BW-1:0]     skid_beat;
    logic              out_valid;
    logic              skid_valid;

    logic [CMPT_W-1:0] fifo_mem [CMPT_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     fifo_cnt;
    logic [CW-1:0]     reserved_cnt;
    logic [CMPT_W-1:0] cmpt_entry;
    logic              push;
    logic              pop;

`ifdef CMPT_TIMESTAMP_EN
    logic [31:0]       ts_cnt;
    logic [31:0]       ts_q;

    // Free-running cycle counter; the value at a packet's first beat is kept for its completion.
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            ts_cnt <= '0;
            ts_q   <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if (s_acc && s_first) ts_q <= ts_cnt;
        end
    end

    assign cur_ts = s_first ? ts_cnt : ts_q;
`else
    assign cur_ts = 32'h0;
`endif

    // Per-beat sideband: first beat uses live cfg/qid, later beats the latched copies.
    always_comb begin
        s_first   = (state == ST_IDLE);
        cur_len   = s_first ? cfg_pkt_len : len_q;
        cur_qid   = s_first ? s_qid : qid_q;
        cur_mty   = s_last ? (6'd0 - cur_len[5:0]) : 6'd0;
        beats_now = s_first ? 16'd1 : (beat_cnt + 16'd1);
        if (cur_len == 16'd0)
            beats_exp = 16'd1;
        else
            beats_exp = {6'd0, cur_len[15:6]} + {15'd0, |cur_len[5:0]};
        len_err   = (beats_now != beats_exp);
    end

    // The open packet already owns a slot, so only packet starts wait on the FIFO.
    assign reserved_cnt = fifo_cnt + {{(CW-1){1'b0}}, (state == ST_PKT)};
    assign s_ready      = ~axi_areset & ~skid_valid
                        & ~(s_first & (reserved_cnt == CW'(CMPT_DEPTH)));
    assign s_acc        = s_valid & s_ready;
    assign push         = s_acc & s_last;
    assign pop          = m_cmpt_tvalid & m_cmpt_tready;

    assign in_beat = {s_last, cur_mty, cur_len, cur_qid, s_data};
    assign {m_c2h_tlast, m_c2h_mty, m_c2h_ctrl_len, m_c2h_ctrl_qid, m_c2h_tdata} = out_beat;
    assign m_c2h_tvalid = out_valid;

    // Output register plus one skid slot; s_ready comes from the registered skid flag.
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || m_c2h_tready) begin
            if (skid_valid) begin
                out_beat   <= skid_beat;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= s_acc;
                if (s_acc) out_beat <= in_beat;
            end
        end else if (s_acc) begin
            skid_beat  <= in_beat;
            skid_valid <= 1'b1;
        end
    end

    // Packet framing: latch len/qid on the first beat, count beats until s_last.
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state    <= ST_IDLE;
            len_q    <= '0;
            qid_q    <= '0;
            beat_cnt <= '0;
        end else if (s_acc) begin
            beat_cnt <= beats_now;
            if (s_first) begin
                len_q <= cfg_pkt_len;
                qid_q <= s_qid;
                if (!s_last) state <= ST_PKT;
            end else if (s_last) begin
                state <= ST_IDLE;
            end
        end
    end

    // Completion entry assembled from the s_last beat's view of the packet.
    always_comb begin
        cmpt_entry              = '0;
        cmpt_entry[15:0]        = cur_len;
        cmpt_entry[31:16]       = seq;
        cmpt_entry[32 +: QID_W] = cur_qid;
        cmpt_entry[43]          = len_err;
        cmpt_entry[95:64]       = cur_ts;
    end

    // Completion storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge axi_aclk) begin
        if (push) fifo_mem[wr_ptr] <= cmpt_entry;
    end

    // FIFO pointers, occupancy and completion sequence number.
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            seq      <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                seq    <= seq + 16'd1;
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                fifo_cnt <= fifo_cnt + CW'(1);
            else if (pop && !push)
                fifo_cnt <= fifo_cnt - CW'(1);
        end
    end

    assign m_cmpt_tvalid = (fifo_cnt != '0);
    assign m_cmpt_tdata  = fifo_mem[rd_ptr];

    // Packet and length-error statistics; the error count saturates.
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            stat_pkt_cnt <= '0;
            stat_len_err <= '0;
        end else begin
            if (m_c2h_tvalid && m_c2h_tready && m_c2h_tlast)
                stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
            if (push && len_err && (stat_len_err != 16'hFFFF))
                stat_len_err <= stat_len_err + 16'd1;
        end
    end

endmodule

// File: tb/tb_c2h_cmpt_packer.sv
// Directed bench for c2h_cmpt_packer: hand-computed beats, mty and
// completion entries, CMPT backpressure, C2H stalls and mid-packet reset.
module tb_c2h_cmpt_packer;

    logic         axi_aclk = 1'b0;
    logic         axi_areset = 1'b1;
    logic [15:0]  cfg_pkt_len = '0;
    logic         s_valid = 1'b0;
    logic [511:0] s_data = '0;
    logic         s_last = 1'b0;
    logic [10:0]  s_qid = '0;
    logic         s_ready;
    logic         m_c2h_tvalid;
    logic [511:0] m_c2h_tdata;
    logic         m_c2h_tlast;
    logic [5:0]   m_c2h_mty;
    logic [15:0]  m_c2h_ctrl_len;
    logic [10:0]  m_c2h_ctrl_qid;
    logic         m_c2h_tready = 1'b1;
    logic         m_cmpt_tvalid;
    logic [127:0] m_cmpt_tdata;
    logic         m_cmpt_tready = 1'b0;
    logic [31:0]  stat_pkt_cnt;
    logic [15:0]  stat_len_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [15:0] d;
        logic        last;
        logic [5:0]  mty;
        logic [15:0] len;
        logic [10:0] qid;
    } beat_t;

    beat_t mon_q[$];

    logic [97:0] prev_sig;
    logic        prev_stall = 1'b0;

    c2h_cmpt_packer dut (
        .axi_aclk       (axi_aclk),
        .axi_areset     (axi_areset),
        .cfg_pkt_len    (cfg_pkt_len),
        .s_valid        (s_valid),
        .s_data         (s_data),
        .s_last         (s_last),
        .s_qid          (s_qid),
        .s_ready        (s_ready),
        .m_c2h_tvalid   (m_c2h_tvalid),
        .m_c2h_tdata    (m_c2h_tdata),
        .m_c2h_tlast    (m_c2h_tlast),
        .m_c2h_mty      (m_c2h_mty),
        .m_c2h_ctrl_len (m_c2h_ctrl_len),
        .m_c2h_ctrl_qid (m_c2h_ctrl_qid),
        .m_c2h_tready   (m_c2h_tready),
        .m_cmpt_tvalid  (m_cmpt_tvalid),
        .m_cmpt_tdata   (m_cmpt_tdata),
        .m_cmpt_tready  (m_cmpt_tready),
        .stat_pkt_cnt   (stat_pkt_cnt),
        .stat_len_err   (stat_len_err)
    );

    always #2 axi_aclk = ~axi_aclk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] exp_cmpt(input logic [15:0] len, input logic [15:0] seq,
                                              input logic [10:0] qid, input logic err);
        logic [127:0] e;
        e        = '0;
        e[15:0]  = len;
        e[31:16] = seq;
        e[42:32] = qid;
        e[43]    = err;
        return e;
    endfunction

    // Record C2H handshakes and verify outputs hold while stalled.
    always @(negedge axi_aclk) begin
        logic [97:0] sig;
        sig = {m_c2h_tdata[63:0], m_c2h_tlast, m_c2h_mty, m_c2h_ctrl_len, m_c2h_ctrl_qid};
        if (prev_stall && !axi_areset)
            check_eq("stall_hold", 128'(sig), 128'(prev_sig));
        if (!axi_areset && m_c2h_tvalid && m_c2h_tready)
            mon_q.push_back({m_c2h_tdata[15:0], m_c2h_tlast, m_c2h_mty, m_c2h_ctrl_len, m_c2h_ctrl_qid});
        prev_stall = !axi_areset && m_c2h_tvalid && !m_c2h_tready;
        prev_sig   = sig;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge axi_aclk);
        #1;
    endtask

    // Present one beat and hold it until accepted (called at posedge+1).
    task automatic send_beat(input logic [7:0] id, input logic [7:0] idx, input logic last,
                             input logic [10:0] qid, input logic [15:0] len);
        logic acc;
        s_valid     = 1'b1;
        s_data      = '0;
        s_data[15:0] = {id, idx};
        s_last      = last;
        s_qid       = qid;
        cfg_pkt_len = len;
        acc = 1'b0;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge axi_aclk);
            acc = s_ready;
            @(posedge axi_aclk);
            #1;
        end
        if (!acc) check_eq("accept_timeout", 128'(acc), 128'(1));
        s_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] id, input int n, input logic [10:0] qid,
                            input logic [15:0] len);
        for (int i = 0; i < n; i++)
            send_beat(id, 8'(i), (i == n - 1), qid, len);
    endtask

    task automatic pop_cmpt(input string tag, input logic [127:0] exp);
        logic [127:0] obs;
        logic got;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge axi_aclk);
            got = m_cmpt_tvalid;
        end
        check_eq({tag, "_cmpt_valid"}, 128'(got), 128'(1));
        obs = m_cmpt_tdata;
`ifdef CMPT_TIMESTAMP_EN
        obs[95:64] = '0;
`endif
        check_eq({tag, "_cmpt"}, obs, exp);
        m_cmpt_tready = 1'b1;
        @(posedge axi_aclk);
        #1;
        m_cmpt_tready = 1'b0;
    endtask

    task automatic check_pkt(input string tag, input int n, input logic [7:0] id,
                             input logic [15:0] len, input logic [10:0] qid, input logic [5:0] mty_last);
        beat_t b;
        check_eq({tag, "_nbeats"}, 128'(mon_q.size()), 128'(n));
        for (int i = 0; i < n && i < mon_q.size(); i++) begin
            b = mon_q[i];
            check_eq($sformatf("%s_b%0d_data", tag, i), 128'(b.d), 128'({id, 8'(i)}));
            check_eq($sformatf("%s_b%0d_last", tag, i), 128'(b.last), 128'(i == n - 1));
            check_eq($sformatf("%s_b%0d_mty", tag, i), 128'(b.mty), 128'((i == n - 1) ? mty_last : 6'd0));
            check_eq($sformatf("%s_b%0d_len", tag, i), 128'(b.len), 128'(len));
            check_eq($sformatf("%s_b%0d_qid", tag, i), 128'(b.qid), 128'(qid));
        end
        mon_q.delete();
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge axi_aclk);
        @(negedge axi_aclk);
        check_eq("rst_s_ready", 128'(s_ready), 128'(0));
        check_eq("rst_c2h_valid", 128'(m_c2h_tvalid), 128'(0));
        check_eq("rst_cmpt_valid", 128'(m_cmpt_tvalid), 128'(0));
        check_eq("rst_pkt_cnt", 128'(stat_pkt_cnt), 128'(0));
        check_eq("rst_len_err", 128'(stat_len_err), 128'(0));
        @(posedge axi_aclk);
        #1;
        axi_areset = 1'b0;
        idle(2);

        // T1: 256 B, qid 5, one-cycle latency
        send_beat(8'd1, 8'd0, 1'b0, 11'd5, 16'd256);
        check_eq("t1_latency_valid", 128'(m_c2h_tvalid), 128'(1));
        check_eq("t1_latency_data", 128'(m_c2h_tdata[15:0]), 128'(16'h0100));
        for (int i = 1; i < 4; i++)
            send_beat(8'd1, 8'(i), (i == 3), 11'd5, 16'd256);
        idle(3);
        check_pkt("t1", 4, 8'd1, 16'd256, 11'd5, 6'd0);
        pop_cmpt("t1", exp_cmpt(16'd256, 16'd0, 11'd5, 1'b0));

        // T2: 100 B in 2 beats, mty 28
        send_pkt(8'd2, 2, 11'd7, 16'd100);
        idle(3);
        check_pkt("t2", 2, 8'd2, 16'd100, 11'd7, 6'd28);
        check_eq("t2_pkt_cnt", 128'(stat_pkt_cnt), 128'(2));
        check_eq("t2_len_err", 128'(stat_len_err), 128'(0));
        pop_cmpt("t2", exp_cmpt(16'd100, 16'd1, 11'd7, 1'b0));

        // T3: 128 B declared, 3 beats sent
        send_pkt(8'd3, 3, 11'd3, 16'd128);
        idle(3);
        check_pkt("t3", 3, 8'd3, 16'd128, 11'd3, 6'd0);
        check_eq("t3_len_err", 128'(stat_len_err), 128'(1));
        pop_cmpt("t3", exp_cmpt(16'd128, 16'd2, 11'd3, 1'b1));

        // T4: CMPT stalled, 17 single-beat packets
        for (int k = 0; k < 16; k++)
            send_beat(8'(8'h10 + k), 8'd0, 1'b1, 11'(k), 16'd64);
        s_valid      = 1'b1;
        s_data       = '0;
        s_data[15:0] = {8'h20, 8'h00};
        s_last       = 1'b1;
        s_qid        = 11'd16;
        cfg_pkt_len  = 16'd64;
        for (int i = 0; i < 3; i++) begin
            @(negedge axi_aclk);
            check_eq($sformatf("t4_blocked_%0d", i), 128'(s_ready), 128'(0));
            @(posedge axi_aclk);
            #1;
        end
        pop_cmpt("t4_k0", exp_cmpt(16'd64, 16'd3, 11'd0, 1'b0));
        @(negedge axi_aclk);
        check_eq("t4_ready_after_pop", 128'(s_ready), 128'(1));
        @(posedge axi_aclk);
        #1;
        s_valid = 1'b0;
        for (int k = 1; k < 17; k++)
            pop_cmpt($sformatf("t4_k%0d", k), exp_cmpt(16'd64, 16'(3 + k), 11'(k), 1'b0));
        idle(3);
        check_eq("t4_nbeats", 128'(mon_q.size()), 128'(17));
        mon_q.delete();
        check_eq("t4_pkt_cnt", 128'(stat_pkt_cnt), 128'(20));
        check_eq("t4_cmpt_empty", 128'(m_cmpt_tvalid), 128'(0));

        // T5: C2H ready toggling during a 4-beat packet
        fork
            send_pkt(8'd5, 4, 11'd2, 16'd256);
            begin
                for (int i = 0; i < 8; i++) begin
                    m_c2h_tready = (i % 2 == 0);
                    @(posedge axi_aclk);
                    #1;
                end
                m_c2h_tready = 1'b1;
            end
        join
        idle(4);
        check_pkt("t5", 4, 8'd5, 16'd256, 11'd2, 6'd0);
        pop_cmpt("t5", exp_cmpt(16'd256, 16'd20, 11'd2, 1'b0));
        check_eq("t5_pkt_cnt", 128'(stat_pkt_cnt), 128'(21));

        // T6: pending completion plus open packet discarded by reset
        send_beat(8'd6, 8'd0, 1'b1, 11'd4, 16'd64);
        send_beat(8'd6, 8'd1, 1'b0, 11'd1, 16'd256);
        s_valid      = 1'b1;
        s_data[15:0] = {8'd6, 8'd2};
        s_last       = 1'b0;
        axi_areset   = 1'b1;
        @(posedge axi_aclk);
        #1;
        check_eq("t6_c2h_valid", 128'(m_c2h_tvalid), 128'(0));
        check_eq("t6_cmpt_valid", 128'(m_cmpt_tvalid), 128'(0));
        check_eq("t6_s_ready", 128'(s_ready), 128'(0));
        check_eq("t6_pkt_cnt_rst", 128'(stat_pkt_cnt), 128'(0));
        s_valid    = 1'b0;
        axi_areset = 1'b0;
        mon_q.delete();
        idle(2);
        send_pkt(8'd7, 2, 11'd9, 16'd128);
        idle(3);
        check_pkt("t6", 2, 8'd7, 16'd128, 11'd9, 6'd0);
        pop_cmpt("t6", exp_cmpt(16'd128, 16'd0, 11'd9, 1'b0));
        check_eq("t6_pkt_cnt", 128'(stat_pkt_cnt), 128'(1));
        check_eq("t6_len_err", 128'(stat_len_err), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
